// File: rtl/serial_adder.sv
// serial_adder: digit-serial unsigned adder with a START/BUSY/DONE handshake.
// One DIGIT-bit adder slice and a carry flip-flop are reused over
// N = WIDTH/DIGIT clock cycles. A WIDTH-bit operation finishes N edges after
// the edge that accepts START. DONE is high for the single FIN cycle that follows.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the SUB input.
// With SUB = 1 the block computes A - B. B is latched inverted and the carry
// loads 1, so CIN is ignored. COUT = 1 then means "no borrow".
//
// Parameter constraints: WIDTH >= 2, 1 <= DIGIT <= WIDTH, and DIGIT divides WIDTH.

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand conditioning at acceptance: plain add, or two's-complement subtract.
  always_comb begin
    b_load     = B;
    carry_load = CIN;
`ifdef SERIAL_ADDER_SUB_EN
    if (SUB) begin
      b_load     = ~B;
      carry_load = 1'b1;
    end
`endif
  end

  // Digit slice: the low DIGIT bits of both shifters plus the running carry.
  // The DIGIT result bits enter the sum register from its MSB end.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and a latch is never inferred.
    slice     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    s_next    = S >> DIGIT;
    s_next[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
    last_step = (cnt == CW'(N - 1));
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so that every flop samples values from before the edge.
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic and handshake outputs. START is honoured only in IDLE or FIN.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (last_step) state_next = FIN;
      end
      FIN: begin
        DONE = 1'b1;
        if (START) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift and add one digit per RUN cycle.
  // S and COUT are written only in RUN, so they keep the last result until the next operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      COUT  <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= slice[DIGIT];
      cnt   <= cnt + CW'(1);
      S     <= s_next;
      if (last_step) COUT <= slice[DIGIT];
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder.
// Four instances with WIDTH = 8 and DIGIT = 1, 2, 4 and 8 share one set of inputs.
// Each scenario checks the instance it targets.
// Inputs are driven, and outputs sampled, 1 time unit after the rising edge.

module tb_serial_adder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       CIN = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       SUB = 1'b0;
`endif

  logic       busy1, done1, cout1;
  logic [7:0] s1;
  logic       busy2, done2, cout2;
  logic [7:0] s2;
  logic       busy4, done4, cout4;
  logic [7:0] s4;
  logic       busy8, done8, cout8;
  logic [7:0] s8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB(SUB),
`endif
    .BUSY(busy1), .DONE(done1), .S(s1), .COUT(cout1));

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB(SUB),
`endif
    .BUSY(busy2), .DONE(done2), .S(s2), .COUT(cout2));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB(SUB),
`endif
    .BUSY(busy4), .DONE(done4), .S(s4), .COUT(cout4));

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB(SUB),
`endif
    .BUSY(busy8), .DONE(done8), .S(s8), .COUT(cout8));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic done_seen;
    tick();
    tick();
    checks++;
    if ({busy1, done1, s1, cout1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state d1: busy=%b done=%b s=%h cout=%b, required all 0",
               busy1, done1, s1, cout1);
    end
    checks++;
    if ({busy8, done8, s8, cout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state d8: busy=%b done=%b s=%h cout=%b, required all 0",
               busy8, done8, s8, cout8);
    end
    RST = 1'b0;
    // Start an operation, then abort it with RST three steps in.
    A = 8'hFF; B = 8'h01; CIN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({busy1, done1, s1, cout1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_midrun d1: busy=%b done=%b s=%h cout=%b, required all 0",
               busy1, done1, s1, cout1);
    end
    RST = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_seen = done_seen | done1 | busy1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done d1: activity seen=%b, required 0", done_seen);
    end
  endtask

  task automatic test_carry_ripple();
    int n;
    do_reset();
    A = 8'hFF; B = 8'h01; CIN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL ripple_busy d1: busy=%b, required 1", busy1);
    end
    A = 8'h00; B = 8'h00; CIN = 1'b1;
    n = 1;
    tick();
    while (done1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL ripple_latency d1: edges=%0d, required 8", n);
    end
    checks++;
    if ({cout1, s1} !== 9'h100) begin
      errors++;
      $display("FAIL ripple_result d1: cout=%b s=%h, required cout=1 s=00", cout1, s1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL ripple_done_pulse d1: done=%b, required 0", done1);
    end
  endtask

  task automatic test_digit_mode();
    int n;
    do_reset();
    A = 8'h7A; B = 8'h96; CIN = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL digit_latency d4: edges=%0d, required 2", n);
    end
    checks++;
    if ({cout4, s4} !== 9'h111) begin
      errors++;
      $display("FAIL digit_result d4: cout=%b s=%h, required cout=1 s=11", cout4, s4);
    end
    checks++;
    if ({cout8, s8} !== 9'h111) begin
      errors++;
      $display("FAIL digit_result d8: cout=%b s=%h, required cout=1 s=11", cout8, s8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    A = 8'h12; B = 8'h34; CIN = 1'b0; START = 1'b1;
    tick();                                   // t0
    START = 1'b0;
    tick();                                   // t1
    START = 1'b1; A = 8'hFF; B = 8'hFF; CIN = 1'b1;
    tick();                                   // t2: ignored in RUN
    START = 1'b0;
    tick();                                   // t3
    START = 1'b1; A = 8'h80; B = 8'h80; CIN = 1'b0;
    tick();                                   // t4: DIGIT=2 now in FIN
    checks++;
    if (done2 !== 1'b1 || {cout2, s2} !== 9'h046) begin
      errors++;
      $display("FAIL b2b_first d2: done=%b cout=%b s=%h, required done=1 cout=0 s=46",
               done2, cout2, s2);
    end
    tick();                                   // t5: accepted from FIN
    START = 1'b0; A = 8'h01; B = 8'h01; CIN = 1'b1;
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart d2: busy=%b done=%b, required busy=1 done=0",
               busy2, done2);
    end
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b_latency d2: edges=%0d, required 4", n);
    end
    checks++;
    if ({cout2, s2} !== 9'h100) begin
      errors++;
      $display("FAIL b2b_second d2: cout=%b s=%h, required cout=1 s=00", cout2, s2);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] av [2] = '{8'h05, 8'h07};
    logic [7:0] bv [2] = '{8'h07, 8'h05};
    logic [8:0] ev [2] = '{9'h0FE, 9'h102};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      A = av[i]; B = bv[i]; CIN = 1'b0; SUB = 1'b1; START = 1'b1;
      tick();
      START = 1'b0; SUB = 1'b0;
      repeat (8) tick();
      checks++;
      if (done1 !== 1'b1 || {cout1, s1} !== ev[i]) begin
        errors++;
        $display("FAIL sub_%0d d1: done=%b cout=%b s=%h, required done=1 {cout,s}=%h",
                 i, done1, cout1, s1, ev[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp_sum;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      A = ra; B = rb; CIN = rc; START = 1'b1;
      tick();
      START = 1'b0;
      A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
      repeat (9) tick();
      checks++;
      if ({cout1, s1} !== exp_sum) begin
        errors++;
        $display("FAIL rand d1 %h+%h+%b: got %h, required %h", ra, rb, rc, {cout1, s1}, exp_sum);
      end
      checks++;
      if ({cout2, s2} !== exp_sum) begin
        errors++;
        $display("FAIL rand d2 %h+%h+%b: got %h, required %h", ra, rb, rc, {cout2, s2}, exp_sum);
      end
      checks++;
      if ({cout4, s4} !== exp_sum) begin
        errors++;
        $display("FAIL rand d4 %h+%h+%b: got %h, required %h", ra, rb, rc, {cout4, s4}, exp_sum);
      end
      checks++;
      if ({cout8, s8} !== exp_sum) begin
        errors++;
        $display("FAIL rand d8 %h+%h+%b: got %h, required %h", ra, rb, rc, {cout8, s8}, exp_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_digit_mode();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
